// File: rtl/des_pkg.sv
// DES constants, FSM state type and small permutation/shift helpers shared by
// the round scheduler and the f-function.
package des_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  localparam int ROUNDS = 16;

  // Tables use DES 1-based numbering: entry n refers to bit n, MSB first.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each box is stored row-major: index = row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  // Decrypt walks the key schedule backwards: K16 equals the PC1 halves, so
  // the first decrypt round does not rotate at all.
  function automatic logic [1:0] shift_amt(input logic [3:0] rcnt, input logic mode);
    logic short_step;
    short_step = (rcnt == 4'd0) || (rcnt == 4'd1) || (rcnt == 4'd8) || (rcnt == 4'd15);
    if (mode && rcnt == 4'd0) return 2'd0;
    return short_step ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                        input logic right);
    case ({right, amt})
      3'b001:  return {x[26:0], x[27]};
      3'b010:  return {x[25:0], x[27:26]};
      3'b101:  return {x[0], x[27:1]};
      3'b110:  return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_f.sv
// Combinational DES f-function: expansion, subkey XOR, S1..S8, P permutation.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s;

  assign x = e_exp(r) ^ k;

  for (genvar i = 0; i < 8; i++) begin : g_sbox
    des_sbox #(.IDX(i)) u_sbox (
      .x(x[47 - 6*i -: 6]),
      .y(s[31 - 4*i -: 4])
    );
  end

  assign f = p_perm(s);

endmodule

// File: rtl/des_sbox.sv
// One DES S-box; IDX (0..7) selects S1..S8.
module des_sbox
  import des_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [5:0] x,
  output logic [3:0] y
);

  // Outer bits pick the row, inner four bits pick the column.
  assign y = 4'(SBOX[IDX][{x[5], x[0], x[4:1]}]);

endmodule

// File: rtl/des_round_sched.sv
// Iterative DES encrypt/decrypt scheduler. Defining DES_TWO_ROUND_EN chains two
// round datapaths per cycle (8-cycle ROUND phase); results are identical.
module des_round_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output state_t      fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its data stable while valid is high and
  // ready is low. in_ready is only high in IDLE, out_valid only in DONE.

`ifdef DES_TWO_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [3:0] LAST_RCNT = 4'(ROUNDS - STEP);
  localparam logic [3:0] RCNT_STEP = 4'(STEP);

  state_t      state, next_state;
  logic [31:0] l, r;
  logic [27:0] c, d;
  logic [3:0]  rcnt;
  logic        mode;

  logic [31:0] l_nxt, r_nxt;
  logic [27:0] c_nxt, d_nxt;

  logic [27:0] c1, d1;
  logic [47:0] k1;
  logic [31:0] f1;

  assign c1 = rot28(c, shift_amt(rcnt, mode), mode);
  assign d1 = rot28(d, shift_amt(rcnt, mode), mode);
  assign k1 = pc2({c1, d1});

  des_f u_f0 (.r(r), .k(k1), .f(f1));

`ifdef DES_TWO_ROUND_EN
  logic [27:0] c2, d2;
  logic [47:0] k2;
  logic [31:0] f2;
  logic [3:0]  rcnt1;

  assign rcnt1 = rcnt + 4'd1;
  assign c2    = rot28(c1, shift_amt(rcnt1, mode), mode);
  assign d2    = rot28(d1, shift_amt(rcnt1, mode), mode);
  assign k2    = pc2({c2, d2});

  des_f u_f1 (.r(l ^ f1), .k(k2), .f(f2));

  assign l_nxt = l ^ f1;
  assign r_nxt = r ^ f2;
  assign c_nxt = c2;
  assign d_nxt = d2;
`else
  assign l_nxt = r;
  assign r_nxt = l ^ f1;
  assign c_nxt = c1;
  assign d_nxt = d1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) next_state = ROUND;
      end
      ROUND: begin
        if (rcnt == LAST_RCNT) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l    <= '0;
      r    <= '0;
      c    <= '0;
      d    <= '0;
      rcnt <= '0;
      mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rcnt <= '0;
          if (in_valid) begin
            {l, r} <= ip(in_data);
            {c, d} <= pc1(in_key);
            mode   <= in_mode;
          end
        end
        ROUND: begin
          l    <= l_nxt;
          r    <= r_nxt;
          c    <= c_nxt;
          d    <= d_nxt;
          rcnt <= (rcnt == LAST_RCNT) ? 4'd0 : rcnt + RCNT_STEP;
        end
        default: rcnt <= '0;
      endcase
    end
  end

  // Final output undoes the last round's swap before the inverse IP.
  assign out_data  = (state == DONE) ? fp({r, l}) : 64'd0;
  assign fsm_state = state;

endmodule

// File: tb/tb_des_round_sched.sv
// Self-checking bench for des_round_sched: known-answer vectors, backpressure,
// mid-round reset and back-to-back random blocks against a reference model.
module tb_des_round_sched;
  import des_pkg::*;

`ifdef DES_TWO_ROUND_EN
  localparam int LAT = 8;
  localparam int SPACING = 10;
`else
  localparam int LAT = 16;
  localparam int SPACING = 18;
`endif

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY3 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT3  = 64'h8787878787878787;
  localparam logic [63:0] CT3  = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  state_t      fsm_state;

  logic [63:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  time         t_acc;

  always #5 clk = ~clk;

  des_round_sched dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent textbook DES: full key schedule first, then 16 Feistel rounds.
  function automatic logic [63:0] ref_des(input logic [63:0] blk, input logic [63:0] key,
                                          input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] lr, res;
    logic [31:0] l, r, t, s, fo;
    logic [47:0] x;
    logic [5:0]  b;
    int          sh;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[6'(i)])];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      for (int j = 0; j < sh; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      ks[4'(i)] = '0;
      for (int j = 0; j < 48; j++) ks[4'(i)][6'(47 - j)] = cd[6'(56 - PC2_T[6'(j)])];
    end
    lr = '0;
    for (int i = 0; i < 64; i++) lr[6'(63 - i)] = blk[6'(64 - IP_T[6'(i)])];
    l = lr[63:32];
    r = lr[31:0];
    for (int i = 0; i < 16; i++) begin
      x = '0;
      for (int j = 0; j < 48; j++) x[6'(47 - j)] = r[5'(32 - E_T[6'(j)])];
      x = x ^ (dec ? ks[4'(15 - i)] : ks[4'(i)]);
      s = '0;
      for (int j = 0; j < 8; j++) begin
        b = 6'(x >> (42 - 6*j));
        s = {s[27:0], 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}])};
      end
      fo = '0;
      for (int j = 0; j < 32; j++) fo[5'(31 - j)] = s[5'(32 - P_T[5'(j)])];
      t = r;
      r = l ^ fo;
      l = t;
    end
    lr = {r, l};
    res = '0;
    for (int i = 0; i < 64; i++) res[6'(63 - i)] = lr[6'(64 - FP_T[6'(i)])];
    return res;
  endfunction

  // Output side of the scoreboard: every completed transfer pops one entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("queue_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) check("result", out_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [63:0] data, input logic [63:0] key, input logic mode,
                      input logic [63:0] exp, input logic hold);
    int w;
    w = 0;
    in_data  = data;
    in_key   = key;
    in_mode  = mode;
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    t_acc = $time;
    exp_q.push_back(exp);
    #1;
    if (!hold) in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    in_key  = {$urandom, $urandom};
    in_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          lat;
    int          seen;
    time         t_prev;
    logic [63:0] rd, rk;
    logic        rm;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_mode = 1'b0;
    out_ready = 1'b1;

    // Reference model sanity against published answers
    check("model_enc", ref_des(PT1, KEY1, 1'b0), CT1);
    check("model_dec", ref_des(CT1, KEY1, 1'b1), PT1);
    check("model_kat3", ref_des(PT3, KEY3, 1'b0), CT3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_state", 64'(fsm_state), 64'(IDLE));

    // Known-answer blocks with latency check
    send(PT1, KEY1, 1'b0, CT1, 1'b0);
    wait_out(lat);
    check("lat_enc", 64'(lat), 64'(LAT));
    wait_drain();
    send(CT1, KEY1, 1'b1, PT1, 1'b0);
    wait_out(lat);
    check("lat_dec", 64'(lat), 64'(LAT));
    wait_drain();
    send(PT3, KEY3, 1'b0, CT3, 1'b0);
    wait_out(lat);
    check("lat_kat3", 64'(lat), 64'(LAT));
    wait_drain();

    // Backpressure with ignored input pulses
    out_ready = 1'b0;
    send(PT1, KEY1, 1'b0, CT1, 1'b0);
    wait_out(lat);
    check("lat_bp", 64'(lat), 64'(LAT));
    for (int i = 0; i < 20; i++) begin
      check("bp_data", out_data, CT1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      in_valid = 1'(i % 2);
      in_data  = {$urandom, $urandom};
      in_key   = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_return", 64'(in_ready), 64'd1);
    wait_drain();

    // Reset in the middle of the round phase
    send(PT1, KEY1, 1'b0, CT1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_state", 64'(fsm_state), 64'(IDLE));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_out", 64'(seen), 64'd0);
    send(PT1, KEY1, 1'b0, CT1, 1'b0);
    wait_out(lat);
    check("lat_after_rst", 64'(lat), 64'(LAT));
    wait_drain();

    // Back-to-back random blocks, in_valid and out_ready held high
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      rd = {$urandom, $urandom};
      rk = {$urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      send(rd, rk, rm, ref_des(rd, rk, rm), 1'b1);
      if (i > 0) check("b2b_spacing", 64'((t_acc - t_prev) / 10), 64'(SPACING));
      t_prev = t_acc;
    end
    in_valid = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
